counter_sequencer: RTL and testbench



---
 rtl/counter_sequencer.sv | 161 ++++++++++++++++
 tb/tb_counter_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for the up/down counter core: prescaled step enables,
// terminal-count detection with one-shot or auto-reload, and load/direction control.
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_en,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_dir,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_SET_LIMIT = 3'd1;
  localparam logic [2:0] OP_SET_PRE   = 3'd2;
  localparam logic [2:0] OP_SET_DIR   = 3'd3;
  localparam logic [2:0] OP_LOAD      = 3'd4;
  localparam logic [2:0] OP_START     = 3'd5;
  localparam logic [2:0] OP_PAUSE     = 3'd6;
  localparam logic [2:0] OP_ABORT     = 3'd7;

  state_t             st_q, st_d;
  logic [WIDTH-1:0]   limit_q, limit_d;
  logic [WIDTH-1:0]   reload_q, reload_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic               mode_auto_q, mode_auto_d;
  logic               dir_q, dir_d;
  logic               load_q, load_d;
  logic [WIDTH-1:0]   load_val_q, load_val_d;
  logic               done_q, done_d;

  logic accept;
  logic in_run;
  logic tick;
  logic terminal;
  logic handle_term;

  assign accept   = cmd_valid && cmd_ready;
  assign in_run   = (st_q == RUN);
  assign tick     = (pre_cnt_q == pre_q);
  assign terminal = in_run && !load_q && (cnt_value == limit_q);

  assign cmd_ready    = !load_q;
  assign cnt_en       = in_run && tick && !load_q && (cnt_value != limit_q);
  assign cnt_load     = load_q;
  assign cnt_load_val = load_val_q;
  assign cnt_dir      = dir_q;
  assign done         = done_q;
  assign busy         = (st_q == RUN) || (st_q == PAUSED);
  assign state        = st_q;

  always_comb begin
    st_d        = st_q;
    limit_d     = limit_q;
    reload_d    = reload_q;
    pre_d       = pre_q;
    pre_cnt_d   = pre_cnt_q;
    mode_auto_d = mode_auto_q;
    dir_d       = dir_q;
    load_d      = 1'b0;
    load_val_d  = load_val_q;
    done_d      = 1'b0;
    handle_term = terminal;

    // The accepting RUN cycle still counts toward the prescale phase, so a
    // PAUSE here freezes the phase as it stands after this cycle.
    if (in_run) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    end

    // Opcodes that claim the edge (ABORT, PAUSE in RUN, LOAD) discard a coincident terminal.
    if (accept) begin
      case (cmd_op)
        OP_NOP:       ;
        OP_SET_LIMIT: limit_d = cmd_data;
        OP_SET_PRE:   pre_d = cmd_data[PRE_W-1:0];
        OP_SET_DIR:   dir_d = cmd_data[0];
        OP_LOAD: begin
          reload_d    = cmd_data;
          load_d      = 1'b1;
          load_val_d  = cmd_data;
          pre_cnt_d   = '0;
          handle_term = 1'b0;
        end
        OP_START: begin
          if (!in_run) begin
            st_d        = RUN;
            mode_auto_d = cmd_data[0];
            if (st_q == IDLE) pre_cnt_d = '0;
          end
        end
        OP_PAUSE: begin
          if (in_run) begin
            st_d        = PAUSED;
            handle_term = 1'b0;
          end
        end
        OP_ABORT: begin
          st_d        = IDLE;
          handle_term = 1'b0;
        end
        default: ;
      endcase
    end

    if (handle_term) begin
      done_d = 1'b1;
      if (mode_auto_q) begin
        load_d     = 1'b1;
        load_val_d = reload_q;
        pre_cnt_d  = '0;
      end else begin
        st_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= IDLE;
      limit_q     <= '0;
      reload_q    <= '0;
      pre_q       <= '0;
      pre_cnt_q   <= '0;
      mode_auto_q <= 1'b0;
      dir_q       <= 1'b1;
      load_q      <= 1'b0;
      load_val_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      limit_q     <= limit_d;
      reload_q    <= reload_d;
      pre_q       <= pre_d;
      pre_cnt_q   <= pre_cnt_d;
      mode_auto_q <= mode_auto_d;
      dir_q       <= dir_d;
      load_q      <= load_d;
      load_val_q  <= load_val_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural counter core closing the loop.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] cnt_value;
  logic       cnt_en;
  logic       cnt_load;
  logic [7:0] cnt_load_val;
  logic       cnt_dir;
  logic       done;
  logic       busy;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  int en_n, en_first, en_last, done_n, done_first, load_n;
  logic [7:0] lval_h [64];
  logic [7:0] cnt_h  [64];
  logic [1:0] st_h   [64];

  counter_sequencer #(.WIDTH(8), .PRE_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cnt_value(cnt_value), .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .cnt_dir(cnt_dir), .done(done), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cnt_value <= 8'd0;
    else if (cnt_load) cnt_value <= cnt_load_val;
    else if (cnt_en) cnt_value <= cnt_dir ? cnt_value + 8'd1 : cnt_value - 8'd1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [2:0] op, input logic [7:0] d);
    int w = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) chk("send_ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'd0;
  endtask

  task automatic observe(input int n);
    en_n = 0; en_first = -1; en_last = -1;
    done_n = 0; done_first = -1; load_n = 0;
    for (int i = 0; i < n; i++) begin
      lval_h[i] = cnt_load_val;
      cnt_h[i]  = cnt_value;
      st_h[i]   = state;
      if (cnt_en) begin
        en_n++;
        if (en_first < 0) en_first = i;
        en_last = i;
      end
      if (done) begin
        done_n++;
        if (done_first < 0) done_first = i;
      end
      if (cnt_load) load_n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset and idle
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt_en", 32'(cnt_en), 32'd0);
    chk("rst_cnt_load", 32'(cnt_load), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dir", 32'(cnt_dir), 32'd1);
    chk("rst_load_val", 32'(cnt_load_val), 32'd0);
    observe(20);
    chk("idle_en_count", 32'(en_n), 32'd0);

    // One-shot count 0 -> 5
    send(3'd4, 8'd0);
    send(3'd1, 8'd5);
    send(3'd2, 8'd0);
    send(3'd5, 8'd0);
    observe(10);
    chk("os_en_count", 32'(en_n), 32'd5);
    chk("os_en_first", 32'(en_first), 32'd0);
    chk("os_en_last", 32'(en_last), 32'd4);
    chk("os_done_count", 32'(done_n), 32'd1);
    chk("os_done_idx", 32'(done_first), 32'd6);
    chk("os_cnt_at_done", 32'(cnt_h[6]), 32'd5);
    chk("os_state_run", 32'(st_h[5]), 32'd1);
    chk("os_state_idle", 32'(st_h[9]), 32'd0);

    // Prescale 3: steps every 4th cycle
    send(3'd2, 8'd3);
    send(3'd4, 8'd0);
    send(3'd1, 8'd2);
    send(3'd5, 8'd0);
    observe(14);
    chk("pre_en_count", 32'(en_n), 32'd2);
    chk("pre_en_first", 32'(en_first), 32'd3);
    chk("pre_en_last", 32'(en_last), 32'd7);
    chk("pre_done_idx", 32'(done_first), 32'd9);
    chk("pre_done_count", 32'(done_n), 32'd1);
    chk("pre_state_idle", 32'(st_h[13]), 32'd0);

    // Auto-reload counting down 10 -> 7
    send(3'd2, 8'd0);
    send(3'd4, 8'd10);
    send(3'd3, 8'd0);
    send(3'd1, 8'd7);
    send(3'd5, 8'd1);
    observe(15);
    chk("ar_done_count", 32'(done_n), 32'd3);
    chk("ar_done_first", 32'(done_first), 32'd4);
    chk("ar_load_count", 32'(load_n), 32'd3);
    chk("ar_load_val", 32'(lval_h[4]), 32'd10);
    chk("ar_en_count", 32'(en_n), 32'd9);
    chk("ar_cnt_term", 32'(cnt_h[3]), 32'd7);
    chk("ar_cnt_reload", 32'(cnt_h[5]), 32'd10);
    chk("ar_state_run", 32'(st_h[14]), 32'd1);
    send(3'd7, 8'd0);
    chk("ar_abort_state", 32'(state), 32'd0);
    observe(10);
    chk("ar_abort_done", 32'(done_n), 32'd0);
    chk("ar_abort_en", 32'(en_n), 32'd0);

    // Pause/resume keeps prescale phase (pre_reg=2)
    send(3'd2, 8'd2);
    send(3'd3, 8'd1);
    send(3'd4, 8'd0);
    send(3'd1, 8'd20);
    send(3'd5, 8'd0);
    observe(4);
    chk("pr_en_before", 32'(en_first), 32'd2);
    send(3'd6, 8'd0);
    chk("pr_paused", 32'(state), 32'd2);
    chk("pr_busy", 32'(busy), 32'd1);
    observe(10);
    chk("pr_paused_en", 32'(en_n), 32'd0);
    chk("pr_paused_cnt", 32'(cnt_h[9]), 32'd1);
    send(3'd5, 8'd0);
    observe(4);
    chk("pr_resume_count", 32'(en_n), 32'd2);
    chk("pr_resume_first", 32'(en_first), 32'd0);
    chk("pr_resume_last", 32'(en_last), 32'd3);
    chk("pr_resume_cnt", 32'(cnt_value), 32'd3);

    // PAUSE on the terminal edge wins: no done
    send(3'd7, 8'd0);
    send(3'd2, 8'd0);
    send(3'd4, 8'd0);
    send(3'd1, 8'd2);
    send(3'd5, 8'd0);
    @(negedge clk);
    @(negedge clk);
    chk("pt_cnt_term", 32'(cnt_value), 32'd2);
    chk("pt_en_term", 32'(cnt_en), 32'd0);
    send(3'd6, 8'd0);
    chk("pt_state", 32'(state), 32'd2);
    chk("pt_done", 32'(done), 32'd0);
    observe(3);
    chk("pt_done_count", 32'(done_n), 32'd0);
    chk("pt_state_hold", 32'(st_h[2]), 32'd2);
    send(3'd7, 8'd0);

    // Back-to-back LOADs stall one cycle
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = 8'h33;
    chk("bb_ready0", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bb_ready_low", 32'(cmd_ready), 32'd0);
    chk("bb_load1", 32'(cnt_load), 32'd1);
    chk("bb_val1", 32'(cnt_load_val), 32'h33);
    cmd_data = 8'h44;
    @(posedge clk);
    @(negedge clk);
    chk("bb_ready_back", 32'(cmd_ready), 32'd1);
    chk("bb_load_gap", 32'(cnt_load), 32'd0);
    chk("bb_val_hold", 32'(cnt_load_val), 32'h33);
    @(posedge clk);
    @(negedge clk);
    chk("bb_load2", 32'(cnt_load), 32'd1);
    chk("bb_val2", 32'(cnt_load_val), 32'h44);
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'd0;
    @(negedge clk);
    chk("bb_load_end", 32'(cnt_load), 32'd0);

    // Asynchronous reset mid-RUN
    send(3'd3, 8'd0);
    send(3'd1, 8'd100);
    send(3'd5, 8'd1);
    chk("ar2_state_run", 32'(state), 32'd1);
    chk("ar2_en", 32'(cnt_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_en", 32'(cnt_en), 32'd0);
    chk("async_load", 32'(cnt_load), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_dir", 32'(cnt_dir), 32'd1);
    chk("async_load_val", 32'(cnt_load_val), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_state", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
